// File: rtl/lcd_bus_master_if.sv
// -----------------------------------------------------------------------------
// lcd_bus_master_if
//
// Groups the word stream feeding lcd_bus_master and the 8080-style LCD pins
// it drives. Signal names keep the i_/o_ prefixes as seen from the master.
//
//   Word stream : i_valid, o_ready, i_rs, i_data[15:0], i_last
//   Control     : i_hw_rst_req (level), o_busy
//   LCD pins    : o_lcd_wr, o_lcd_rs, o_lcd_cs_n, o_lcd_rst_n,
//                 o_lcd_data[BUS_WIDTH-1:0]
//
// modport master : the bus master (consumes words, drives the pins)
// modport slave  : the word source plus the panel side
// -----------------------------------------------------------------------------
interface lcd_bus_master_if #(
   parameter int BUS_WIDTH = 16
);
   logic                 i_valid;
   logic                 o_ready;
   logic                 i_rs;
   logic [15:0]          i_data;
   logic                 i_last;
   logic                 i_hw_rst_req;
   logic                 o_busy;
   logic                 o_lcd_wr;
   logic                 o_lcd_rs;
   logic                 o_lcd_cs_n;
   logic                 o_lcd_rst_n;
   logic [BUS_WIDTH-1:0] o_lcd_data;

   modport master (
      input  i_valid, i_rs, i_data, i_last, i_hw_rst_req,
      output o_ready, o_busy,
      output o_lcd_wr, o_lcd_rs, o_lcd_cs_n, o_lcd_rst_n, o_lcd_data
   );

   modport slave (
      output i_valid, i_rs, i_data, i_last, i_hw_rst_req,
      input  o_ready, o_busy,
      input  o_lcd_wr, o_lcd_rs, o_lcd_cs_n, o_lcd_rst_n, o_lcd_data
   );
endinterface

// File: rtl/lcd_bus_master.sv
// -----------------------------------------------------------------------------
// lcd_bus_master
//
// Write-only 8080-style parallel LCD bus master. Words arriving on a
// valid/ready stream are turned into CS_N/RS/DATA/WR waveforms with
// programmable setup, strobe-low and recovery widths. In 8-bit mode each
// 16-bit word is sent as two beats, high byte first. The block also
// generates the panel hardware-reset pulse after power-up and on request.
//
// Ports
//   i_mclk  : clock
//   i_rst_n : asynchronous active-low reset
//   bus     : lcd_bus_master_if.master (word stream, control, LCD pins)
//
// All o_lcd_* pins come straight from flops. o_ready and o_busy are decoded
// from the state register (o_ready additionally from i_hw_rst_req).
// -----------------------------------------------------------------------------
module lcd_bus_master #(
   parameter int BUS_WIDTH    = 16,
   parameter int SETUP_CYC    = 1,
   parameter int WR_LOW_CYC   = 2,
   parameter int WR_HIGH_CYC  = 2,
   parameter int CS_IDLE_CYC  = 4,
   parameter int RST_LOW_CYC  = 8,
   parameter int RST_WAIT_CYC = 16
) (
   input logic              i_mclk,
   input logic              i_rst_n,
   lcd_bus_master_if.master bus
);

   // Parameter legality is checked at elaboration.
   if (BUS_WIDTH != 8 && BUS_WIDTH != 16) begin : g_bad_width
      $error("lcd_bus_master: BUS_WIDTH must be 8 or 16");
   end
   if (SETUP_CYC < 1 || WR_LOW_CYC < 1 || WR_HIGH_CYC < 1 ||
       CS_IDLE_CYC < 1 || RST_LOW_CYC < 1 || RST_WAIT_CYC < 1) begin : g_bad_timing
      $error("lcd_bus_master: all cycle counts must be >= 1");
   end

   function automatic int max_i(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

   // One shared counter times every state; in IDLE it doubles as the
   // CS_N auto-release counter.
   localparam int MAX_CYC = max_i(max_i(max_i(SETUP_CYC, WR_LOW_CYC),
                                        max_i(WR_HIGH_CYC, CS_IDLE_CYC)),
                                  max_i(RST_LOW_CYC, RST_WAIT_CYC));
   localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

   localparam logic [CNT_W-1:0] SETUP_LAST    = CNT_W'(SETUP_CYC - 1);
   localparam logic [CNT_W-1:0] WR_LOW_LAST   = CNT_W'(WR_LOW_CYC - 1);
   localparam logic [CNT_W-1:0] WR_HIGH_LAST  = CNT_W'(WR_HIGH_CYC - 1);
   localparam logic [CNT_W-1:0] CS_IDLE_LAST  = CNT_W'(CS_IDLE_CYC - 1);
   localparam logic [CNT_W-1:0] RST_LOW_LAST  = CNT_W'(RST_LOW_CYC - 1);
   localparam logic [CNT_W-1:0] RST_WAIT_LAST = CNT_W'(RST_WAIT_CYC - 1);

   typedef enum logic [2:0] {
      ST_RST_LOW,
      ST_RST_WAIT,
      ST_IDLE,
      ST_SETUP,
      ST_WR_LOW,
      ST_WR_HIGH
   } state_t;

   state_t               state_q;
   logic [CNT_W-1:0]     cnt_q;
   logic                 wr_q;
   logic                 rs_q;
   logic                 cs_n_q;
   logic                 lcd_rst_n_q;
   logic [BUS_WIDTH-1:0] data_q;
   logic [7:0]           lo_q;     // low byte held for the second 8-bit beat
   logic                 last_q;
   logic                 beat_q;   // 1 while sending the second 8-bit beat

   // NOTE: every register here, including the data latch, gets an async reset
   // so the pins go to safe values the instant i_rst_n falls, with no clock.
   always_ff @(posedge i_mclk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q     <= ST_RST_LOW;
         cnt_q       <= '0;
         wr_q        <= 1'b1;
         rs_q        <= 1'b0;
         cs_n_q      <= 1'b1;
         lcd_rst_n_q <= 1'b0;
         data_q      <= '0;
         lo_q        <= '0;
         last_q      <= 1'b0;
         beat_q      <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments only, so every branch below reads
         // the pre-edge value of each register regardless of statement order.
         case (state_q)
            ST_RST_LOW: begin
               if (cnt_q == RST_LOW_LAST) begin
                  state_q     <= ST_RST_WAIT;
                  cnt_q       <= '0;
                  lcd_rst_n_q <= 1'b1;
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end

            ST_RST_WAIT: begin
               if (cnt_q == RST_WAIT_LAST) begin
                  state_q <= ST_IDLE;
                  cnt_q   <= '0;
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end

            ST_IDLE: begin
               if (bus.i_hw_rst_req) begin
                  // Reset request wins over a pending word.
                  state_q     <= ST_RST_LOW;
                  cnt_q       <= '0;
                  cs_n_q      <= 1'b1;
                  lcd_rst_n_q <= 1'b0;
               end else if (bus.i_valid) begin
                  state_q <= ST_SETUP;
                  cnt_q   <= '0;
                  cs_n_q  <= 1'b0;
                  rs_q    <= bus.i_rs;
                  // 16-bit: whole word; 8-bit: high byte goes first.
                  data_q  <= bus.i_data[15 -: BUS_WIDTH];
                  lo_q    <= bus.i_data[7:0];
                  last_q  <= bus.i_last;
                  beat_q  <= 1'b0;
               end else if (cnt_q == CS_IDLE_LAST) begin
                  // Counter saturates here; CS_N stays released.
                  cs_n_q <= 1'b1;
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end

            ST_SETUP: begin
               if (cnt_q == SETUP_LAST) begin
                  state_q <= ST_WR_LOW;
                  cnt_q   <= '0;
                  wr_q    <= 1'b0;
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end

            ST_WR_LOW: begin
               if (cnt_q == WR_LOW_LAST) begin
                  state_q <= ST_WR_HIGH;
                  cnt_q   <= '0;
                  wr_q    <= 1'b1;
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end

            ST_WR_HIGH: begin
               if (cnt_q == WR_HIGH_LAST) begin
                  cnt_q <= '0;
                  if (BUS_WIDTH == 8 && !beat_q) begin
                     state_q <= ST_SETUP;
                     beat_q  <= 1'b1;
                     data_q  <= BUS_WIDTH'(lo_q);
                  end else begin
                     state_q <= ST_IDLE;
                     if (last_q) cs_n_q <= 1'b1;
                  end
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end

            default: begin
               state_q <= ST_RST_LOW;
               cnt_q   <= '0;
            end
         endcase
      end
   end

   assign bus.o_ready     = (state_q == ST_IDLE) && !bus.i_hw_rst_req;
   assign bus.o_busy      = (state_q != ST_IDLE);
   assign bus.o_lcd_wr    = wr_q;
   assign bus.o_lcd_rs    = rs_q;
   assign bus.o_lcd_cs_n  = cs_n_q;
   assign bus.o_lcd_rst_n = lcd_rst_n_q;
   assign bus.o_lcd_data  = data_q;

endmodule

// File: doc/lcd_bus_master.md
# lcd_bus_master

Parametrised 8080-style write-only parallel LCD bus master, the synthesizable successor to the bench's Brain LCD source model. It turns a valid/ready stream of command/data words into WR/RS/CS_N/RST_N/DATA waveforms. Setup, strobe and recovery timing are programmable, the bus width is 8 or 16 bits, and it generates the panel hardware-reset sequence. It sits in front of any block consuming the `i_lcd_*` bus: as a stimulus source in the bench, or as a pass-through re-driver in hardware.

## Interface
- `BUS_WIDTH`, 16: LCD data bus width, 8 or 16; any other value is an elaboration error.
- `SETUP_CYC`, 1: cycles DATA/RS/CS_N are valid before WR falls; must be ≥1.
- `WR_LOW_CYC`, 2: WR low pulse width in cycles; must be ≥1.
- `WR_HIGH_CYC`, 2: WR high hold/recovery after the rising edge; must be ≥1.
- `CS_IDLE_CYC`, 4: consecutive idle cycles before CS_N auto-deasserts; must be ≥1.
- `RST_LOW_CYC`, 8: RST_N low width; must be ≥1.
- `RST_WAIT_CYC`, 16: wait after RST_N rises before the first transfer; must be ≥1.
- `i_mclk`  in  1: clock.
- `i_rst_n`  in  1: asynchronous active-low reset.
- `i_valid`  in  1: word available.
- `o_ready`  out  1: word accepted when `i_valid & o_ready`.
- `i_rs`  in  1: 0 = command, 1 = data.
- `i_data`  in  16: word; in 8-bit mode both bytes are sent.
- `i_last`  in  1: release CS_N after this word.
- `i_hw_rst_req`  in  1: level request for a hardware-reset sequence.
- `o_busy`  out  1: high in any state other than IDLE.
- `o_lcd_wr`  out  1: write strobe, idle high, panel latches on the rising edge.
- `o_lcd_rs`  out  1: register select.
- `o_lcd_cs_n`  out  1: chip select, active low.
- `o_lcd_rst_n`  out  1: panel reset, active low.
- `o_lcd_data`  out  BUS_WIDTH: bus data.

## Operation
- **Reset values.** On `i_rst_n` = 0, outputs take these values immediately:
  - `o_lcd_wr`=1, `o_lcd_rs`=0, `o_lcd_cs_n`=1, `o_lcd_rst_n`=0, `o_lcd_data`=0
  - `o_ready`=0, `o_busy`=1
  - FSM = RST_LOW
- **FSM states:** RST_LOW, RST_WAIT, IDLE, SETUP, WR_LOW, WR_HIGH.
- **RST_LOW.** `o_lcd_rst_n`=0 and `o_lcd_cs_n`=1 for RST_LOW_CYC cycles, then RST_WAIT.
- **RST_WAIT.** `o_lcd_rst_n`=1 for RST_WAIT_CYC cycles, then IDLE.
- **IDLE.** `o_ready` = ~`i_hw_rst_req`.
  - `i_hw_rst_req` has priority over `i_valid`: next state RST_LOW and `o_lcd_cs_n`←1.
  - On accept, latch `i_rs`, `i_data` and `i_last`, then go to SETUP.
- **SETUP.** In the first SETUP cycle, `o_lcd_cs_n`=0 and `o_lcd_rs`/`o_lcd_data` are driven with the current beat. `o_lcd_wr`=1 for SETUP_CYC cycles, then WR_LOW.
- **WR_LOW.** `o_lcd_wr`=0 for WR_LOW_CYC cycles, then WR_HIGH.
- **WR_HIGH.** `o_lcd_wr`=1 for WR_HIGH_CYC cycles. Then:
  - 8-bit mode, first beat done: return to SETUP for the second beat.
  - Otherwise: return to IDLE.
- **Beat order.**
  - 16-bit mode: one beat, `i_data[15:0]`.
  - 8-bit mode: two beats, `i_data[15:8]` then `i_data[7:0]`. RS is identical on both beats.
- **Data/RS hold.** DATA and RS stay stable from the first SETUP cycle through the last WR_HIGH cycle. They keep their last value in IDLE.
- **CS_N release.**
  - If the latched last = 1, `o_lcd_cs_n` goes to 1 on entry to IDLE.
  - Otherwise CS_N stays 0 across back-to-back words. An idle counter counts IDLE cycles without an accept; when it reaches CS_IDLE_CYC, CS_N goes to 1. The counter clears on accept.
- **Hardware-reset requests.** `i_hw_rst_req` asserted mid-transfer is ignored until IDLE; the transfer completes intact. A request held through RST_WAIT retriggers RST_LOW on entry to IDLE.
- **Async reset mid-transfer.** Aborts immediately to the reset values; the partial word is lost.

## Timing
- Accept cycle t0 (IDLE). Relative to it:
  - SETUP spans t0+1 .. t0+SETUP_CYC.
  - WR falls at t0+1+SETUP_CYC.
  - WR rises at t0+1+SETUP_CYC+WR_LOW_CYC.
- Word period per beat = SETUP_CYC+WR_LOW_CYC+WR_HIGH_CYC.
- 16-bit back-to-back throughput: one word every 1+SETUP_CYC+WR_LOW_CYC+WR_HIGH_CYC cycles (defaults: 6).
- 8-bit back-to-back throughput: one word every 1+2·(SETUP_CYC+WR_LOW_CYC+WR_HIGH_CYC) cycles (defaults: 11).
- From release of `i_rst_n`, the first `o_ready`=1 occurs after RST_LOW_CYC+RST_WAIT_CYC cycles (defaults: 24).
- All outputs are registered; no combinational path from inputs to `o_lcd_*`. `o_ready` is decoded from the state register and `i_hw_rst_req`.

## Test plan
- **Power-up.** Release `i_rst_n` with defaults -> `o_lcd_rst_n` low for 8 cycles, high for 16 more; `o_ready` rises on cycle 24; `o_lcd_cs_n`=1 throughout.
- **Single command, 16-bit mode.** Word `i_rs`=0, `i_data`=16'h002C, `i_last`=1 -> CS_N low at t0+1; WR low t0+2..t0+3; data 16'h002C stable t0+1..t0+5; CS_N high at t0+6.
- **8-bit mode.** BUS_WIDTH=8, word 16'hA55A with `i_rs`=1 -> two WR pulses carrying 8'hA5 then 8'h5A; RS=1 on both; 11-cycle word period when streaming.
- **Back-to-back stream.** 4 words with `i_valid` held high, `i_last` only on word 4 -> CS_N stays low across all 4 words; `o_ready` asserted exactly one cycle per 6; CS_N rises after word 4.
- **CS auto-release.** Single word with `i_last`=0, then no traffic -> CS_N rises exactly 4 IDLE cycles after the transfer ends.
- **Hardware reset and async reset.**
  - Assert `i_hw_rst_req` during WR_LOW -> the current word completes, then `o_lcd_rst_n` pulses low for 8 cycles.
  - Assert `i_rst_n`=0 mid-transfer -> outputs immediately take the reset values.
